// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
//   Shared definitions for the VRAM arbiter: default bus widths, the default
//   starvation limit, the issue-slot state encoding and the owner tag that
//   travels down the pipeline with each access.
//   No ports (package).
// -----------------------------------------------------------------------------
package vram_pkg;

  localparam int VRAM_ADDR_W     = 32;
  localparam int VRAM_DATA_W     = 32;
  localparam int VRAM_STARVE_MAX = 7;

  // Which requester owns the VRAM port during the current cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PPU_SLOT = 2'd1,
    CPU_SLOT = 2'd2
  } state_t;

  // Tag carried alongside an in-flight access so the response stage knows
  // whose data is coming back from the VRAM.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    PPU  = 2'd1,
    CPU  = 2'd2
  } owner_t;

  function automatic owner_t slot_owner(input state_t slot);
    case (slot)
      PPU_SLOT: return PPU;
      CPU_SLOT: return CPU;
      default:  return NONE;
    endcase
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
//   Bundles the PPU read port, the CPU request/ack port and the VRAM port.
//   Modports:
//     slave  - the arbiter side (takes requests, drives responses and VRAM)
//     master - the client side (PPU, CPU and the VRAM model)
//   Signals:
//     ppu_req/ppu_addr -> ppu_data/ppu_valid
//     cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack
//     mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata (one cycle read latency)
// -----------------------------------------------------------------------------
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic [DATA_W-1:0] ppu_data;
  logic              ppu_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output ppu_data, ppu_valid, cpu_rdata, cpu_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  ppu_data, ppu_valid, cpu_rdata, cpu_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Shares one single-port VRAM between a PPU read port and a CPU read/write
//   port. One grant per cycle; the PPU normally has strict priority.
//   Pipeline: issue stage (registered mem_* + slot state) -> VRAM read
//   (one cycle, tag follows in tag_pipe_reg) -> response stage (registered
//   ppu_*/cpu_*). Response appears two edges after the request is sampled.
//
//   Ports:
//     clk    - clock, all state on rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - vram_arbiter_if.slave (PPU, CPU and VRAM signals)
//
//   Optional feature: define VRAM_ARB_STARVE_GUARD_EN to add a saturating
//   starvation counter that forces a CPU grant after STARVE_MAX consecutive
//   blocked cycles. Without it the PPU always wins.
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int STARVE_MAX = VRAM_STARVE_MAX
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_range
    $error("vram_arbiter: STARVE_MAX must be in 1..255");
  end

  state_t            state_reg;
  state_t            state_next;
  owner_t            tag_pipe_reg;
  logic              cpu_out_reg;

  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic              ppu_valid_reg;
  logic [DATA_W-1:0] ppu_data_reg;
  logic              cpu_ack_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;

  logic              cpu_pending;
  logic              cpu_priority;

  // A held cpu_req is only a new request once its previous access has acked.
  assign cpu_pending = bus.cpu_req && !cpu_out_reg;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_reg;
  assign cpu_priority = (starve_reg == 8'(STARVE_MAX));
`else
  assign cpu_priority = 1'b0;
`endif

  always_comb begin
    state_next = IDLE;
    if (cpu_pending && (!bus.ppu_req || cpu_priority)) begin
      state_next = CPU_SLOT;
    end else if (bus.ppu_req) begin
      state_next = PPU_SLOT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tag_pipe_reg  <= NONE;
      cpu_out_reg   <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      ppu_valid_reg <= 1'b0;
      ppu_data_reg  <= '0;
      cpu_ack_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      starve_reg    <= '0;
`endif
    end else begin
      // Issue stage
      state_reg <= state_next;
      case (state_next)
        PPU_SLOT: begin
          mem_en_reg   <= 1'b1;
          mem_we_reg   <= 1'b0;
          mem_addr_reg <= bus.ppu_addr;
        end
        CPU_SLOT: begin
          mem_en_reg   <= 1'b1;
          mem_we_reg   <= bus.cpu_we;
          mem_addr_reg <= bus.cpu_addr;
          if (bus.cpu_we) begin
            mem_wdata_reg <= bus.cpu_wdata;
          end
        end
        default: begin
          // Address and write data keep their last value while idle.
          mem_en_reg <= 1'b0;
          mem_we_reg <= 1'b0;
        end
      endcase

      // Tag follows the access while the VRAM performs its read.
      tag_pipe_reg <= slot_owner(state_reg);

      // Response stage; data registers only change on their own pulse.
      ppu_valid_reg <= (tag_pipe_reg == PPU);
      cpu_ack_reg   <= (tag_pipe_reg == CPU);
      if (tag_pipe_reg == PPU) begin
        ppu_data_reg <= bus.mem_rdata;
      end
      if (tag_pipe_reg == CPU) begin
        cpu_rdata_reg <= bus.mem_rdata;
      end

      // Grant and ack cannot coincide: a grant needs cpu_out_reg low, while
      // a CPU tag in the pipe implies it is high.
      if (state_next == CPU_SLOT) begin
        cpu_out_reg <= 1'b1;
      end else if (tag_pipe_reg == CPU) begin
        cpu_out_reg <= 1'b0;
      end

`ifdef VRAM_ARB_STARVE_GUARD_EN
      if (state_next == CPU_SLOT) begin
        starve_reg <= '0;
      end else if (cpu_pending && (starve_reg != 8'(STARVE_MAX))) begin
        starve_reg <= starve_reg + 8'd1;
      end
`endif
    end
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.ppu_valid = ppu_valid_reg;
  assign bus.ppu_data  = ppu_data_reg;
  assign bus.cpu_ack   = cpu_ack_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//   Directed bench for vram_arbiter with a behavioural VRAM, a PPU scoreboard
//   (data + arrival cycle) and a CPU scoreboard (ack order + read data).
//   Covers VRAM_ARB_STARVE_GUARD_EN builds as well (STARVE_MAX = 3).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return 16'(a * 16'd37 + 16'h1000);
  endfunction

  // VRAM model: one-cycle registered read, reloaded while in reset.
  logic [15:0] vram [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) vram[i] <= init_val(16'(i));
    end else if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= vram[bus.mem_addr[7:0]];
    end
  end

  function automatic void check(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endfunction

  typedef struct { logic [15:0] data; int at; } ppu_exp_t;
  typedef struct { logic rd; logic [15:0] data; } cpu_exp_t;
  ppu_exp_t ppu_q[$];
  cpu_exp_t cpu_q[$];
  bit ppu_check_en = 1'b1;
  int cpu_ack_cnt  = 0;

  // Monitor: pops the scoreboards whenever the DUT produces a response.
  always @(negedge clk) begin
    ppu_exp_t pe;
    cpu_exp_t ce;
    if (bus.ppu_valid && ppu_check_en) begin
      if (ppu_q.size() == 0) begin
        check("ppu_valid_unexpected", 32'(bus.ppu_valid), 0);
      end else begin
        pe = ppu_q.pop_front();
        $display("ppu_valid  cyc=%0d data=0x%04h (want 0x%04h @%0d)",
                 cyc, bus.ppu_data, pe.data, pe.at);
        check("ppu_data", 32'(bus.ppu_data), 32'(pe.data));
        check("ppu_latency", cyc, pe.at);
      end
    end
    if (bus.cpu_ack) begin
      cpu_ack_cnt++;
      if (cpu_q.size() == 0) begin
        check("cpu_ack_unexpected", 32'(bus.cpu_ack), 0);
      end else begin
        ce = cpu_q.pop_front();
        $display("cpu_ack    cyc=%0d %s rdata=0x%04h", cyc,
                 ce.rd ? "read " : "write", bus.cpu_rdata);
        if (ce.rd) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(ce.data));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"},    32'(bus.mem_en),    0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    check({tag, "_ppu_valid"}, 32'(bus.ppu_valid), 0);
    check({tag, "_ppu_data"},  32'(bus.ppu_data),  0);
    check({tag, "_cpu_ack"},   32'(bus.cpu_ack),   0);
    check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
  endtask

  task automatic wait_ack(input string tag, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.cpu_ack !== 1'b1 && k < 40);
    check(tag, 32'(bus.cpu_ack), 1);
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd);
    cpu_exp_t e;
    int k;
    e.rd = !we;
    e.data = exp_rd;
    cpu_q.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    wait_ack("cpu_access_ack", k);
    check("cpu_access_latency", k, 3);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic ppu_read(input logic [15:0] a);
    ppu_exp_t e;
    e.data = init_val(a);
    e.at   = cyc + 3;
    ppu_q.push_back(e);
    bus.ppu_req  = 1'b1;
    bus.ppu_addr = a;
    @(negedge clk);
    bus.ppu_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((ppu_q.size() != 0 || cpu_q.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ppu_pending"}, ppu_q.size(), 0);
    check({tag, "_cpu_pending"}, cpu_q.size(), 0);
  endtask

  initial begin
    int c;
    int k;
    int acks0;
    ppu_exp_t e;

    bus.ppu_req = 1'b0; bus.ppu_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single PPU read, then idle port holds its address
    ppu_read(16'h0010);
    @(negedge clk);
    check("idle_mem_en", 32'(bus.mem_en), 0);
    check("idle_mem_we", 32'(bus.mem_we), 0);
    check("idle_mem_addr_hold", 32'(bus.mem_addr), 32'h10);
    drain("single_ppu");

    // Back-to-back PPU reads 0..7
    for (int i = 0; i < 8; i++) begin
      e.data = init_val(16'(i));
      e.at   = cyc + 3;
      ppu_q.push_back(e);
      bus.ppu_req  = 1'b1;
      bus.ppu_addr = 16'(i);
      @(negedge clk);
    end
    bus.ppu_req = 1'b0;
    drain("b2b_ppu");
    check("ppu_valid_low_between", 32'(bus.ppu_valid), 0);
    check("ppu_data_hold", 32'(bus.ppu_data), 32'(init_val(16'd7)));

    // CPU write then read back
    cpu_access(1'b1, 16'h0020, 16'h1234, 16'h0000);
    cpu_access(1'b0, 16'h0020, 16'h0000, 16'h1234);
    @(negedge clk);
    check("cpu_ack_low_between", 32'(bus.cpu_ack), 0);
    check("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'h1234);
    drain("cpu_rw");

    // Contention: both held, PPU wins first
    ppu_check_en = 1'b0;
    acks0 = cpu_ack_cnt;
    c = cyc;
    cpu_q.push_back('{rd: 1'b1, data: 16'hA5A5});
    bus.ppu_req = 1'b1; bus.ppu_addr = 16'h0010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    repeat (3) @(negedge clk);
    check("contention_ppu_valid", 32'(bus.ppu_valid), 1);
    check("contention_ppu_data", 32'(bus.ppu_data), 32'hA5A5);
    check("contention_no_early_ack", cpu_ack_cnt, acks0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    wait_ack("starve_ack", k);
    check("starve_ack_cycle", cyc, c + 6);
`else
    repeat (10) @(negedge clk);
    check("contention_no_cpu_ack", cpu_ack_cnt, acks0);
    bus.ppu_req = 1'b0;
    wait_ack("contention_ack_after_ppu", k);
    check("contention_ack_latency", k, 3);
`endif
    bus.cpu_req = 1'b0;
    bus.ppu_req = 1'b0;
    repeat (4) @(negedge clk);
    drain("contention");

    // CPU request withdrawn before grant is never issued
    acks0 = cpu_ack_cnt;
    bus.ppu_req = 1'b1; bus.ppu_addr = 16'h0010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    bus.ppu_req = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_no_ack", cpu_ack_cnt, acks0);
    ppu_check_en = 1'b1;
    ppu_read(16'h0030);
    drain("drop");

    // Reset one cycle after a CPU grant
    acks0 = cpu_ack_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check("pre_reset_mem_en", 32'(bus.mem_en), 1);
    check("pre_reset_mem_we", 32'(bus.mem_we), 1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    #1;
    check_zero("reset_mid");
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("reset_no_late_ack", cpu_ack_cnt, acks0);
    ppu_read(16'h0010);
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
